// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive front end.
// Sample-counter compare points are derived from the oversampling ratio.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 8;
    localparam int FRAME_BITS = 8;

    localparam logic [3:0] SCNT_EARLY = 4'(SAMPLE_MID - 1);
    localparam logic [3:0] SCNT_MID   = 4'(SAMPLE_MID);
    localparam logic [3:0] SCNT_LATE  = 4'(SAMPLE_MID + 1);
    localparam logic [3:0] SCNT_LAST  = 4'(OVERSAMPLE - 1);

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive byte buffer with occupancy count and registered overrun pulse.
// A push into a full FIFO succeeds only when a pop frees a slot in the same cycle.
module uart_rx_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             valid_o,
    output logic [LW-1:0]    level_o,
    output logic             overrun_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             overrun_q, overrun_d;
    logic             full, empty, do_push, do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == LW'(DEPTH));
    assign do_pop  = pop_i && !empty;
    assign do_push = push_i && (!full || do_pop);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        overrun_d = push_i && full && !do_pop;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      level_d = level_q + 1'b1;
        else if (do_pop && !do_push) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (do_push) mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            overrun_q <= overrun_d;
        end
    end

    assign head_o    = mem_q[rd_ptr_q];
    assign valid_o   = !empty;
    assign level_o   = level_q;
    assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receiver: pin synchroniser, oversample tick, majority-vote frame FSM,
// receive FIFO and occupancy-driven rts.
module uart_rx_deser
    import uart_rx_pkg::*;
#(
    parameter  int FIFO_DEPTH    = 4,
    parameter  int RTS_THRESHOLD = 3,
    parameter  int DIV_WIDTH     = 16,
    localparam int LW            = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [DIV_WIDTH-1:0] rate_i,
    input  logic                 rx_i,
    output logic [7:0]           rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic [LW-1:0]        rx_level_o,
    output logic                 rts_o,
    output logic                 framing_error_o,
    output logic                 overrun_o
);

    rx_state_t              state_q, state_d;
    logic [1:0]             sync_q;
    logic [DIV_WIDTH-1:0]   tcnt_q, tcnt_d;
    logic [DIV_WIDTH-1:0]   rate_q, rate_d;
    logic [3:0]             scnt_q, scnt_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [FRAME_BITS-1:0]  shreg_q, shreg_d;
    logic                   s_early_q, s_early_d;
    logic                   s_mid_q, s_mid_d;
    logic                   ferr_q, ferr_d;
    logic                   rts_q, rts_d;
    logic                   rxs, tick, decide, bit_end, bit_val, push;

    assign rxs     = sync_q[1];
    assign tick    = (tcnt_q == rate_q);
    assign decide  = tick && (scnt_q == SCNT_LATE);
    assign bit_end = tick && (scnt_q == SCNT_LAST);
    assign bit_val = majority3(s_early_q, s_mid_q, rxs);

    // The divisor is only reloaded at a wrap so a rate change never truncates a tick.
    always_comb begin
        tcnt_d = tick ? '0 : tcnt_q + 1'b1;
        rate_d = tick ? rate_i : rate_q;
    end

    always_comb begin
        state_d   = state_q;
        scnt_d    = scnt_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        s_early_d = s_early_q;
        s_mid_d   = s_mid_q;
        ferr_d    = 1'b0;
        push      = 1'b0;
        if (tick) begin
            scnt_d = scnt_q + 4'd1;
            if (scnt_q == SCNT_EARLY) s_early_d = rxs;
            if (scnt_q == SCNT_MID)   s_mid_d   = rxs;
        end
        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d = START;
                    scnt_d  = '0;
                end
            end
            START: begin
                if (decide && bit_val) begin
                    state_d = IDLE;
                end else if (bit_end) begin
                    state_d  = DATA;
                    bitcnt_d = '0;
                end
            end
            DATA: begin
                if (decide) shreg_d = {bit_val, shreg_q[FRAME_BITS-1:1]};
                if (bit_end) begin
                    if (bitcnt_q == 3'(FRAME_BITS - 1)) state_d = STOP;
                    else bitcnt_d = bitcnt_q + 3'd1;
                end
            end
            STOP: begin
                // Leaving at mid-stop gives half a bit of slack for a fast sender.
                if (decide) begin
                    if (bit_val) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign rts_d = (int'(rx_level_o) < RTS_THRESHOLD);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            sync_q    <= 2'b11;
            tcnt_q    <= '0;
            rate_q    <= '0;
            scnt_q    <= '0;
            bitcnt_q  <= '0;
            shreg_q   <= '0;
            s_early_q <= 1'b0;
            s_mid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            rts_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= {sync_q[0], rx_i};
            tcnt_q    <= tcnt_d;
            rate_q    <= rate_d;
            scnt_q    <= scnt_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            s_early_q <= s_early_d;
            s_mid_q   <= s_mid_d;
            ferr_q    <= ferr_d;
            rts_q     <= rts_d;
        end
    end

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FRAME_BITS)
    ) u_fifo (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (push),
        .push_data_i (shreg_q),
        .pop_i       (rx_ready_i),
        .head_o      (rx_data_o),
        .valid_o     (rx_valid_o),
        .level_o     (rx_level_o),
        .overrun_o   (overrun_o)
    );

    assign rts_o           = rts_q;
    assign framing_error_o = ferr_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Directed bench for uart_rx_deser: frames driven bit by bit on rx, results
// compared against hand-computed bytes, levels, pulse counts and latencies.
module tb_uart_rx_deser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic        rx_ready = 1'b0;
    logic [15:0] rate = 16'd0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [2:0]  rx_level;
    logic        rts;
    logic        framing_error;
    logic        overrun;

    int checks = 0;
    int passed = 0;
    int cyc = 0;
    int t_start = 0;
    int rise_cyc = -1;
    int lvl3_cyc = -1;
    int rts_fall_cyc = -1;
    int fe_cnt = 0, ov_cnt = 0, fe_wide = 0, ov_wide = 0;
    logic valid_prev = 1'b0, rts_prev = 1'b0, fe_prev = 1'b0, ov_prev = 1'b0;
    logic [2:0] lvl_prev = 3'd0;

    uart_rx_deser dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .rate_i          (rate),
        .rx_i            (rx),
        .rx_data_o       (rx_data),
        .rx_valid_o      (rx_valid),
        .rx_ready_i      (rx_ready),
        .rx_level_o      (rx_level),
        .rts_o           (rts),
        .framing_error_o (framing_error),
        .overrun_o       (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_valid && !valid_prev) rise_cyc = cyc;
        if (rx_level == 3'd3 && lvl_prev != 3'd3) lvl3_cyc = cyc;
        if (!rts && rts_prev) rts_fall_cyc = cyc;
        if (framing_error) fe_cnt++;
        if (framing_error && fe_prev) fe_wide++;
        if (overrun) ov_cnt++;
        if (overrun && ov_prev) ov_wide++;
        valid_prev = rx_valid;
        lvl_prev   = rx_level;
        rts_prev   = rts;
        fe_prev    = framing_error;
        ov_prev    = overrun;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // Drives one 8N1 frame; clock k of the frame is presented to edge t_start+k.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                              input int pop_k, input int abort_k);
        int cpb;
        int idx;
        cpb = 16 * (int'(rate) + 1);
        for (int k = 0; k < 10 * cpb; k++) begin
            @(negedge clk);
            if (k == abort_k) begin
                reset = 1'b1;
                rx = 1'b1;
                return;
            end
            if (k == 0) t_start = cyc + 1;
            idx = k / cpb;
            if (idx == 0)      rx = 1'b0;
            else if (idx <= 8) rx = b[idx-1];
            else               rx = stop_bit;
            if (k == pop_k)          rx_ready = 1'b1;
            else if (k == pop_k + 1) rx_ready = 1'b0;
        end
    endtask

    task automatic pop_byte(output logic [7:0] d);
        @(negedge clk);
        d = rx_data;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset;
        idle(3);
        checks++; if (rx_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", rx_valid); else passed++;
        checks++; if (rx_level !== 3'd0) $display("FAIL reset_level got %0d exp 0", rx_level); else passed++;
        checks++; if (rx_data !== 8'h00) $display("FAIL reset_data got %h exp 00", rx_data); else passed++;
        checks++; if (rts !== 1'b0) $display("FAIL reset_rts got %b exp 0", rts); else passed++;
        checks++; if (framing_error !== 1'b0 || overrun !== 1'b0)
            $display("FAIL reset_pulses got fe=%b ov=%b exp 0 0", framing_error, overrun); else passed++;
        @(negedge clk);
        reset = 1'b0;
        idle(1);
        checks++; if (rts !== 1'b1) $display("FAIL rts_after_reset got %b exp 1", rts); else passed++;
    endtask

    task automatic test_basic;
        logic [7:0] d;
        send_frame(8'h55, 1'b1, -1, -1);
        idle(1);
        checks++; if (rise_cyc !== t_start + 156)
            $display("FAIL basic_latency got edge %0d exp %0d", rise_cyc, t_start + 156); else passed++;
        checks++; if (rx_data !== 8'h55) $display("FAIL basic_data got %h exp 55", rx_data); else passed++;
        checks++; if (rx_level !== 3'd1) $display("FAIL basic_level got %0d exp 1", rx_level); else passed++;
        idle(20);
        checks++; if (rx_data !== 8'h55 || rx_valid !== 1'b1)
            $display("FAIL basic_hold got %h/%b exp 55/1", rx_data, rx_valid); else passed++;
        pop_byte(d);
        idle(1);
        checks++; if (rx_level !== 3'd0 || rx_valid !== 1'b0)
            $display("FAIL basic_pop got level %0d valid %b exp 0 0", rx_level, rx_valid); else passed++;
    endtask

    task automatic test_glitch;
        int fe0;
        logic [7:0] d;
        fe0 = fe_cnt;
        rate = 16'd3;
        idle(10);
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(150);
        checks++; if (rx_level !== 3'd0) $display("FAIL glitch_level got %0d exp 0", rx_level); else passed++;
        checks++; if (fe_cnt - fe0 !== 0) $display("FAIL glitch_ferr got %0d exp 0", fe_cnt - fe0); else passed++;
        rate = 16'd0;
        idle(10);
        send_frame(8'h3C, 1'b1, -1, -1);
        idle(1);
        checks++; if (rx_data !== 8'h3C || rx_level !== 3'd1)
            $display("FAIL glitch_recover got %h/%0d exp 3c/1", rx_data, rx_level); else passed++;
        pop_byte(d);
    endtask

    task automatic test_framing;
        int fe0;
        logic [7:0] d;
        fe0 = fe_cnt;
        send_frame(8'hA3, 1'b0, -1, -1);
        idle(2);
        checks++; if (fe_cnt - fe0 !== 1) $display("FAIL ferr_count got %0d exp 1", fe_cnt - fe0); else passed++;
        checks++; if (rx_level !== 3'd0) $display("FAIL ferr_level got %0d exp 0", rx_level); else passed++;
        idle(640);
        checks++; if (fe_cnt - fe0 !== 1) $display("FAIL break_count got %0d exp 1", fe_cnt - fe0); else passed++;
        checks++; if (fe_wide !== 0) $display("FAIL ferr_width got %0d wide cycles exp 0", fe_wide); else passed++;
        rx = 1'b1;
        idle(20);
        send_frame(8'h96, 1'b1, -1, -1);
        idle(1);
        checks++; if (rx_data !== 8'h96 || rx_level !== 3'd1)
            $display("FAIL break_recover got %h/%0d exp 96/1", rx_data, rx_level); else passed++;
        checks++; if (fe_cnt - fe0 !== 1) $display("FAIL ferr_after got %0d exp 1", fe_cnt - fe0); else passed++;
        pop_byte(d);
    endtask

    task automatic test_flow_overrun;
        int ov0;
        logic [7:0] d;
        ov0 = ov_cnt;
        rx_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1, -1);
        idle(2);
        checks++; if (rx_level !== 3'd4) $display("FAIL flow_level got %0d exp 4", rx_level); else passed++;
        checks++; if (ov_cnt - ov0 !== 1) $display("FAIL overrun_count got %0d exp 1", ov_cnt - ov0); else passed++;
        checks++; if (ov_wide !== 0) $display("FAIL overrun_width got %0d wide cycles exp 0", ov_wide); else passed++;
        checks++; if (rts_fall_cyc !== lvl3_cyc + 1)
            $display("FAIL rts_fall got edge %0d exp %0d", rts_fall_cyc, lvl3_cyc + 1); else passed++;
        checks++; if (rts !== 1'b0) $display("FAIL rts_full got %b exp 0", rts); else passed++;
        for (int i = 1; i <= 4; i++) begin
            pop_byte(d);
            checks++; if (d !== 8'(i)) $display("FAIL drain_%0d got %h exp %h", i, d, 8'(i)); else passed++;
        end
        idle(2);
        checks++; if (rx_level !== 3'd0 || rts !== 1'b1)
            $display("FAIL drain_end got level %0d rts %b exp 0 1", rx_level, rts); else passed++;
    endtask

    task automatic test_full_pushpop;
        int ov0;
        logic [7:0] d;
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h22; exp_b[1] = 8'h33; exp_b[2] = 8'h44; exp_b[3] = 8'h77;
        ov0 = ov_cnt;
        send_frame(8'h11, 1'b1, -1, -1);
        send_frame(8'h22, 1'b1, -1, -1);
        send_frame(8'h33, 1'b1, -1, -1);
        send_frame(8'h44, 1'b1, -1, -1);
        send_frame(8'h77, 1'b1, 156, -1);
        idle(2);
        checks++; if (rx_level !== 3'd4) $display("FAIL full_level got %0d exp 4", rx_level); else passed++;
        checks++; if (ov_cnt - ov0 !== 0) $display("FAIL full_overrun got %0d exp 0", ov_cnt - ov0); else passed++;
        for (int i = 0; i < 4; i++) begin
            pop_byte(d);
            checks++; if (d !== exp_b[i]) $display("FAIL full_drain_%0d got %h exp %h", i, d, exp_b[i]); else passed++;
        end
    endtask

    task automatic test_reset_midframe;
        int fe0, ov0;
        logic [7:0] d;
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send_frame(8'h5A, 1'b1, -1, -1);
        send_frame(8'hB5, 1'b1, -1, 5 * 16 + 8);
        idle(1);
        checks++; if (rx_valid !== 1'b0 || rx_level !== 3'd0)
            $display("FAIL midreset_fifo got valid %b level %0d exp 0 0", rx_valid, rx_level); else passed++;
        checks++; if (rx_data !== 8'h00 || rts !== 1'b0)
            $display("FAIL midreset_out got data %h rts %b exp 00 0", rx_data, rts); else passed++;
        idle(2);
        reset = 1'b0;
        idle(20);
        send_frame(8'hC3, 1'b1, -1, -1);
        idle(1);
        checks++; if (rx_data !== 8'hC3 || rx_level !== 3'd1)
            $display("FAIL midreset_next got %h/%0d exp c3/1", rx_data, rx_level); else passed++;
        checks++; if (fe_cnt - fe0 !== 0 || ov_cnt - ov0 !== 0)
            $display("FAIL midreset_pulses got fe %0d ov %0d exp 0 0", fe_cnt - fe0, ov_cnt - ov0); else passed++;
        checks++; if (rts !== 1'b1) $display("FAIL midreset_rts got %b exp 1", rts); else passed++;
        pop_byte(d);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_flow_overrun();
        test_full_pushpop();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
